// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and write-FSM states for the slave-side channel responders.
// Used by write_slave and axi_burst_addr_gen; intended for reuse by the read slave.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_e;

    // True when a burst must not write memory at all: reserved burst type,
    // illegal WRAP length, or a beat wider than the data bus.
    function automatic logic aw_illegal(input logic [1:0] burst,
                                        input logic [3:0] len,
                                        input logic [1:0] size,
                                        input int         max_size);
        logic wrap_len_ok;
        wrap_len_ok = len inside {4'd1, 4'd3, 4'd7, 4'd15};
        return (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !wrap_len_ok) ||
               (int'(size) > max_size);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI3 next-beat address for FIXED, INCR and WRAP bursts.
// Reserved burst type holds the address.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_len,
    input  logic [1:0]    i_size,
    input  logic [1:0]    i_burst,
    output logic [AW-1:0] o_next_addr
);

    logic [AW-1:0] w_step;
    logic [AW-1:0] w_incr;
    logic [AW-1:0] w_wrap_mask;

    assign w_step      = AW'(1) << i_size;
    assign w_incr      = i_addr + w_step;
    // Wrap window is the whole burst footprint: (len+1) beats of 2^size bytes.
    assign w_wrap_mask = ((AW'(i_len) + AW'(1)) << i_size) - AW'(1);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        o_next_addr = i_addr;
        case (i_burst)
            BURST_INCR: o_next_addr = w_incr;
            BURST_WRAP: o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
            default:    o_next_addr = i_addr;
        endcase
    end

endmodule

// File: rtl/write_slave.sv
// AXI3 write-channel slave: one AW burst, AWLEN+1 W beats into the memory port, one B response.
// Optional macro WSLV_AW_SKID_EN adds a one-entry AW holding register so the next burst can queue.
module write_slave
    import axi_pkg::*;
#(
    parameter int buswidth = 32,
    parameter int IDW      = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [IDW-1:0]        AWID,
    input  logic [buswidth-1:0]   AWADDR,
    input  logic [3:0]            AWLEN,
    input  logic [1:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic [1:0]            AWLOCK,
    input  logic [3:0]            AWCACHE,
    input  logic [2:0]            AWPROT,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [IDW-1:0]        WID,
    input  logic [buswidth-1:0]   WDATA,
    input  logic [buswidth/8-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [IDW-1:0]        BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [buswidth-1:0]   address_out,
    output logic [buswidth-1:0]   data_out,
    output logic [buswidth/8-1:0] strb_out,
    output logic                  memwrite
);

    localparam int MAX_SIZE = $clog2(buswidth / 8);

    typedef struct packed {
        logic [IDW-1:0]      id;
        logic [buswidth-1:0] addr;
        logic [3:0]          len;
        logic [1:0]          size;
        logic [1:0]          burst;
        logic                nowrite;
    } aw_req_t;

    wr_state_e           r_state;
    wr_state_e           w_next_state;
    aw_req_t             r_req;
    aw_req_t             w_aw_in;
    aw_req_t             w_load_src;
    logic                w_load;
    logic [3:0]          r_cnt;
    logic                r_slverr;
    logic [buswidth-1:0] w_next_addr;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_last_beat;
    logic                w_id_err;
    logic                w_unused;

    assign w_unused = ^{AWLOCK, AWCACHE, AWPROT};

    assign w_aw_in = '{
        id:      AWID,
        addr:    AWADDR,
        len:     AWLEN,
        size:    AWSIZE,
        burst:   AWBURST,
        nowrite: aw_illegal(AWBURST, AWLEN, AWSIZE, MAX_SIZE)
    };

    assign w_aw_hs     = AWVALID && AWREADY;
    assign w_w_hs      = WVALID && WREADY;
    assign w_b_hs      = BVALID && BREADY;
    assign w_last_beat = (r_cnt == r_req.len);
    assign w_id_err    = (WID != r_req.id);

    assign WREADY      = (r_state == DATA);
    assign BVALID      = (r_state == RESP);
    assign BID         = r_req.id;
    assign BRESP       = r_slverr ? RESP_SLVERR : RESP_OKAY;

    assign address_out = r_req.addr;
    assign data_out    = WDATA;
    assign strb_out    = WSTRB;
    assign memwrite    = w_w_hs && !(r_req.nowrite || w_id_err);

    axi_burst_addr_gen #(
        .AW (buswidth)
    ) u_addr_gen (
        .i_addr      (r_req.addr),
        .i_len       (r_req.len),
        .i_size      (r_req.size),
        .i_burst     (r_req.burst),
        .o_next_addr (w_next_addr)
    );

`ifdef WSLV_AW_SKID_EN
    aw_req_t r_hold;
    logic    r_hold_valid;
    logic    w_hold_push;
    logic    w_hold_pop;

    // The holding register is always empty in IDLE, so this also covers the IDLE case.
    assign AWREADY     = !r_hold_valid;
    assign w_hold_push = w_aw_hs && ((r_state == DATA) || ((r_state == RESP) && !w_b_hs));
    assign w_hold_pop  = (r_state == RESP) && w_b_hs && r_hold_valid;

    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else if (w_hold_push) begin
            r_hold       <= w_aw_in;
            r_hold_valid <= 1'b1;
        end else if (w_hold_pop) begin
            r_hold_valid <= 1'b0;
        end
    end
`else
    assign AWREADY = (r_state == IDLE);
`endif

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_src   = w_aw_in;
        case (r_state)
            IDLE: begin
                if (w_aw_hs) begin
                    w_load       = 1'b1;
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_w_hs && w_last_beat) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (w_b_hs) begin
`ifdef WSLV_AW_SKID_EN
                    if (r_hold_valid) begin
                        w_load       = 1'b1;
                        w_load_src   = r_hold;
                        w_next_state = DATA;
                    end else if (w_aw_hs) begin
                        w_load       = 1'b1;
                        w_next_state = DATA;
                    end else begin
                        w_next_state = IDLE;
                    end
`else
                    w_next_state = IDLE;
`endif
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; reset here is synchronous and active-high.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            r_state  <= IDLE;
            r_req    <= '0;
            r_cnt    <= '0;
            r_slverr <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_req    <= w_load_src;
                r_cnt    <= '0;
                r_slverr <= w_load_src.nowrite;
            end else if (w_w_hs) begin
                r_req.addr <= w_next_addr;
                r_cnt      <= r_cnt + 4'd1;
                // WLAST disagreeing with the beat count is flagged but never shortens the burst.
                if (w_id_err || (WLAST != w_last_beat)) begin
                    r_slverr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_write_slave.sv
// Scoreboard bench for write_slave: directed bursts push expected memory writes and B responses,
// a negedge monitor pops and compares them. Define WSLV_AW_SKID_EN to also exercise the AW skid.
module tb_write_slave;
    import axi_pkg::*;

`ifdef WSLV_AW_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b1;
    logic [1:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [3:0]  AWLEN = '0;
    logic [1:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic [1:0]  AWLOCK = '0;
    logic [3:0]  AWCACHE = '0;
    logic [2:0]  AWPROT = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [1:0]  WID = '0;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [31:0] address_out;
    logic [31:0] data_out;
    logic [3:0]  strb_out;
    logic        memwrite;

    always #5 ACLK = ~ACLK;

    write_slave #(.buswidth(32), .IDW(2)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .address_out(address_out), .data_out(data_out), .strb_out(strb_out), .memwrite(memwrite)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } mem_t;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] resp;
    } b_t;

    mem_t exp_mem_q[$];
    b_t   exp_b_q[$];
    mem_t mon_mem;
    b_t   mon_b;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every memory write and every B handshake must match the head of its queue.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            if (memwrite) begin
                if (exp_mem_q.size() == 0) begin
                    check("mem_unexpected_write", memwrite, 1'b0);
                end else begin
                    mon_mem = exp_mem_q.pop_front();
                    check("mem_write", {address_out, data_out, strb_out}, mon_mem);
                end
            end
            if (BVALID && BREADY) begin
                if (exp_b_q.size() == 0) begin
                    check("b_unexpected", BVALID, 1'b0);
                end else begin
                    mon_b = exp_b_q.pop_front();
                    check("b_resp", {BID, BRESP}, mon_b);
                end
            end
        end
    end

    task automatic push_mem(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        mem_t m;
        m.addr = addr;
        m.data = data;
        m.strb = strb;
        exp_mem_q.push_back(m);
    endtask

    task automatic push_b(input logic [1:0] id, input logic [1:0] resp);
        b_t b;
        b.id   = id;
        b.resp = resp;
        exp_b_q.push_back(b);
    endtask

    task automatic do_aw(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] size, input logic [1:0] burst);
        int   n;
        logic rdy;
        n = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
        AWVALID = 1'b1;
        do begin
            @(negedge ACLK);
            rdy = AWREADY;
            @(posedge ACLK);
            n++;
        end while (!rdy && n < 50);
        #1 AWVALID = 1'b0;
        check("aw_accept", rdy, 1'b1);
    endtask

    // One W beat; wr says whether the bench expects it to reach memory at exp_addr.
    task automatic do_w(input logic [1:0] id, input logic [31:0] data, input logic [3:0] strb,
                        input logic last, input logic wr, input logic [31:0] exp_addr);
        int   n;
        logic rdy;
        n = 0;
        if (wr) push_mem(exp_addr, data, strb);
        WID = id; WDATA = data; WSTRB = strb; WLAST = last;
        WVALID = 1'b1;
        do begin
            @(negedge ACLK);
            rdy = WREADY;
            @(posedge ACLK);
            n++;
        end while (!rdy && n < 50);
        #1 WVALID = 1'b0;
        WLAST = 1'b0;
        check("w_accept", rdy, 1'b1);
    endtask

    task automatic wait_b();
        int   n;
        logic v;
        n = 0;
        do begin
            @(negedge ACLK);
            v = BVALID;
            n++;
        end while (!v && n < 50);
        check("b_valid_seen", v, 1'b1);
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state while reset is held
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_awready", AWREADY, 1'b1);
        check("rst_wready", WREADY, 1'b0);
        check("rst_bvalid", BVALID, 1'b0);
        check("rst_bid", BID, 2'd0);
        check("rst_bresp", BRESP, 2'b00);
        check("rst_memwrite", memwrite, 1'b0);
        check("rst_address_out", address_out, 32'h0);
        @(posedge ACLK);
        #1 ARESETn = 1'b0;

        // INCR, 4 beats of 4 bytes
        push_b(2'd2, 2'b00);
        do_aw(2'd2, 32'h100, 4'd3, 2'd2, 2'b01);
        do_w(2'd2, 32'hA000_0000, 4'hF, 1'b0, 1'b1, 32'h100);
        do_w(2'd2, 32'hA000_0001, 4'hF, 1'b0, 1'b1, 32'h104);
        do_w(2'd2, 32'hA000_0002, 4'hF, 1'b0, 1'b1, 32'h108);
        do_w(2'd2, 32'hA000_0003, 4'hF, 1'b1, 1'b1, 32'h10C);
        wait_b();

        // WRAP, 4 beats wrapping inside a 16-byte window
        push_b(2'd1, 2'b00);
        do_aw(2'd1, 32'h38, 4'd3, 2'd2, 2'b10);
        do_w(2'd1, 32'hB000_0000, 4'hF, 1'b0, 1'b1, 32'h38);
        do_w(2'd1, 32'hB000_0001, 4'hF, 1'b0, 1'b1, 32'h3C);
        do_w(2'd1, 32'hB000_0002, 4'hF, 1'b0, 1'b1, 32'h30);
        do_w(2'd1, 32'hB000_0003, 4'hF, 1'b1, 1'b1, 32'h34);
        wait_b();

        // FIXED with partial strobes, then hold B off for 5 cycles
        push_b(2'd3, 2'b00);
        do_aw(2'd3, 32'h200, 4'd2, 2'd2, 2'b00);
        do_w(2'd3, 32'hC000_0000, 4'b0011, 1'b0, 1'b1, 32'h200);
        do_w(2'd3, 32'hC000_0001, 4'b0011, 1'b0, 1'b1, 32'h200);
        BREADY = 1'b0;
        do_w(2'd3, 32'hC000_0002, 4'b0011, 1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("bp_bvalid", BVALID, 1'b1);
            check("bp_bid", BID, 2'd3);
            check("bp_bresp", BRESP, 2'b00);
            check("bp_awready", AWREADY, SKID);
        end
        @(posedge ACLK);
        #1 BREADY = 1'b1;
        wait_b();

        // Reserved burst type: beats consumed, nothing written, SLVERR
        push_b(2'd0, 2'b10);
        do_aw(2'd0, 32'h300, 4'd1, 2'd2, 2'b11);
        do_w(2'd0, 32'hD000_0000, 4'hF, 1'b0, 1'b0, 32'h0);
        do_w(2'd0, 32'hD000_0001, 4'hF, 1'b1, 1'b0, 32'h0);
        wait_b();

        // WID mismatch on beat 1 only suppresses that beat; address still advances
        push_b(2'd1, 2'b10);
        do_aw(2'd1, 32'h400, 4'd2, 2'd2, 2'b01);
        do_w(2'd1, 32'hE000_0000, 4'hF, 1'b0, 1'b1, 32'h400);
        do_w(2'd2, 32'hE000_0001, 4'hF, 1'b0, 1'b0, 32'h0);
        do_w(2'd1, 32'hE000_0002, 4'hF, 1'b1, 1'b1, 32'h408);
        wait_b();

        // WLAST early on beat 0 and missing on beat 1: both written, SLVERR
        push_b(2'd2, 2'b10);
        do_aw(2'd2, 32'h500, 4'd1, 2'd2, 2'b01);
        do_w(2'd2, 32'hF000_0000, 4'h5, 1'b1, 1'b1, 32'h500);
        do_w(2'd2, 32'hF000_0001, 4'hA, 1'b0, 1'b1, 32'h504);
        wait_b();

        // Oversized beat and illegal WRAP length: no writes, SLVERR
        push_b(2'd1, 2'b10);
        do_aw(2'd1, 32'h940, 4'd0, 2'd3, 2'b01);
        do_w(2'd1, 32'h1111_0000, 4'hF, 1'b1, 1'b0, 32'h0);
        wait_b();
        push_b(2'd0, 2'b10);
        do_aw(2'd0, 32'h980, 4'd2, 2'd2, 2'b10);
        do_w(2'd0, 32'h2222_0000, 4'hF, 1'b0, 1'b0, 32'h0);
        do_w(2'd0, 32'h2222_0001, 4'hF, 1'b0, 1'b0, 32'h0);
        do_w(2'd0, 32'h2222_0002, 4'hF, 1'b1, 1'b0, 32'h0);
        wait_b();

        // Single-beat burst: BVALID the cycle after the only beat
        push_b(2'd2, 2'b00);
        do_aw(2'd2, 32'h600, 4'd0, 2'd2, 2'b01);
        do_w(2'd2, 32'h6666_6666, 4'hF, 1'b1, 1'b1, 32'h600);
        @(negedge ACLK);
        check("lat_bvalid", BVALID, 1'b1);
        @(posedge ACLK);
        #1;

        // Reset during beat 2 of an 8-beat INCR: burst abandoned, no B
        do_aw(2'd0, 32'h700, 4'd7, 2'd2, 2'b01);
        do_w(2'd0, 32'h7000_0000, 4'hF, 1'b0, 1'b1, 32'h700);
        do_w(2'd0, 32'h7000_0001, 4'hF, 1'b0, 1'b1, 32'h704);
        WID = 2'd0; WDATA = 32'h7000_0002; WSTRB = 4'hF; WVALID = 1'b1;
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1 WVALID = 1'b0;
        @(negedge ACLK);
        check("midrst_awready", AWREADY, 1'b1);
        check("midrst_wready", WREADY, 1'b0);
        check("midrst_bvalid", BVALID, 1'b0);
        @(posedge ACLK);
        #1 ARESETn = 1'b0;
        push_b(2'd3, 2'b00);
        do_aw(2'd3, 32'h800, 4'd1, 2'd2, 2'b01);
        do_w(2'd3, 32'h8000_0000, 4'hF, 1'b0, 1'b1, 32'h800);
        do_w(2'd3, 32'h8000_0001, 4'hF, 1'b1, 1'b1, 32'h804);
        wait_b();

`ifdef WSLV_AW_SKID_EN
        // Second AW queued during DATA; its first beat goes the cycle after the first B
        push_b(2'd1, 2'b00);
        push_b(2'd2, 2'b00);
        do_aw(2'd1, 32'h900, 4'd1, 2'd2, 2'b01);
        do_aw(2'd2, 32'hA00, 4'd0, 2'd2, 2'b01);
        do_w(2'd1, 32'h9000_0000, 4'hF, 1'b0, 1'b1, 32'h900);
        do_w(2'd1, 32'h9000_0001, 4'hF, 1'b1, 1'b1, 32'h904);
        push_mem(32'hA00, 32'hAAAA_0000, 4'hF);
        WID = 2'd2; WDATA = 32'hAAAA_0000; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        check("skid_b1_valid", BVALID, 1'b1);
        check("skid_wready_in_resp", WREADY, 1'b0);
        @(posedge ACLK);
        @(negedge ACLK);
        check("skid_wready_after_b", WREADY, 1'b1);
        @(posedge ACLK);
        #1 WVALID = 1'b0;
        WLAST = 1'b0;
        wait_b();
`endif

        repeat (3) @(posedge ACLK);
        check("mem_q_drained", exp_mem_q.size(), 0);
        check("b_q_drained", exp_b_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/write_slave.md
Name: write_slave

Overview:
- AXI3-style write-channel responder: the write-direction counterpart of the existing read slave.
- Accepts one AW burst, consumes AWLEN+1 W beats, drives byte-strobed writes into the local memory model, then returns one B response.
- Sits between the interconnect's slave-side write channels and the memory module, beside the read slave in each master/slave node.

Parameters:
- buswidth, 32, address and data width in bits; WSTRB width is buswidth/8.
- IDW, 2, slave-side transaction ID width.

Ports:
- ACLK  in  1  clock; all state changes on rising edge.
- ARESETn  in  1  synchronous, active-high reset, sampled on ACLK; asserting high resets the block.
- AWID  in  IDW  write address ID.
- AWADDR  in  buswidth  burst start address.
- AWLEN  in  4  beats minus 1.
- AWSIZE  in  2  log2 bytes per beat.
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- AWLOCK  in  2  accepted, ignored.
- AWCACHE  in  4  accepted, ignored.
- AWPROT  in  3  accepted, ignored.
- AWVALID  in  1  AW valid.
- AWREADY  out  1  AW ready.
- WID  in  IDW  write data ID.
- WDATA  in  buswidth  write data.
- WSTRB  in  buswidth/8  byte enables.
- WLAST  in  1  last beat marker.
- WVALID  in  1  W valid.
- WREADY  out  1  W ready.
- BID  out  IDW  response ID, equal to the captured AWID.
- BRESP  out  2  00 OKAY, 10 SLVERR.
- BVALID  out  1  response valid.
- BREADY  in  1  response ready.
- address_out  out  buswidth  memory byte address of the current beat.
- data_out  out  buswidth  memory write data (WDATA passthrough).
- strb_out  out  buswidth/8  memory byte enables.
- memwrite  out  1  memory write enable, one cycle per written beat.

Behaviour:
- Reset: state IDLE; AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=00, memwrite=0, address_out=0, beat counter=0, error flag=0. Reset mid-burst abandons the burst; no B is sent for it.
- FSM IDLE -> DATA on AWVALID&&AWREADY. Capture ID, address, length, size and burst; clear the beat counter and error flag.
- FSM DATA -> RESP on the W handshake with beat counter == AWLEN.
- FSM RESP -> IDLE on BVALID&&BREADY.
- AWREADY=1 only in IDLE. WREADY=1 only in DATA. BVALID=1 only in RESP; BID, BRESP held stable until BREADY.
- Memory write: memwrite = WVALID && WREADY && !beat_err, combinational in the handshake cycle. address_out = registered beat address; data_out = WDATA; strb_out = WSTRB. The memory samples on the same edge.
- Address update per accepted beat:
  - FIXED: address unchanged.
  - INCR: address += 1<<size.
  - WRAP: address = (address & ~mask) | ((address + (1<<size)) & mask), where mask = ((AWLEN+1)<<size)-1.
- Burst length: exactly AWLEN+1 W handshakes are always consumed; beat count is authoritative over WLAST.
- Errors (any one latches SLVERR for the burst):
  - AWBURST=11: no memwrite for any beat.
  - WRAP with AWLEN not in {1,3,7,15}: no memwrite for any beat.
  - AWSIZE > log2(buswidth/8): no memwrite for any beat.
  - WID != captured AWID on a beat: that beat's memwrite suppressed.
  - WLAST=1 before the final beat, or WLAST=0 on the final beat: beat still written.
- Minimum latency: AW accept at cycle 0, first beat at cycle 1, B visible the cycle after the last beat; a 1-beat burst has BVALID at cycle 2.

Optional Feature:
- Macro WSLV_AW_SKID_EN.
- Defined: one-entry AW holding register. AWREADY=1 whenever the register is empty, including in DATA and RESP. RESP->IDLE loads a held entry directly into DATA (IDLE skipped).
- Undefined: AWREADY=1 only in IDLE, as above.

Decomposition:
- Shared axi_pkg holds:
  - burst encodings: BURST_FIXED, BURST_INCR, BURST_WRAP.
  - response encodings: RESP_OKAY, RESP_EXOKAY, RESP_SLVERR.
  - write FSM state encodings: IDLE, DATA, RESP.
- Sub-module axi_burst_addr_gen: combinational next-address logic from address, len, size and burst. Reusable by the read slave.

Test Plan:
- INCR: AWADDR=0x100, AWLEN=3, AWSIZE=2, WID=AWID=2 -> memwrite at 0x100, 0x104, 0x108, 0x10C; BID=2, BRESP=00.
- WRAP: AWADDR=0x38, AWLEN=3, AWSIZE=2 -> addresses 0x38, 0x3C, 0x30, 0x34; BRESP=00.
- FIXED, AWLEN=2, WSTRB=4'b0011 -> three writes to the same address with strb_out=0011; backpressure BREADY=0 for 5 cycles -> BVALID, BID, BRESP held stable, no new AWREADY.
- AWBURST=11, AWLEN=1 -> 2 beats accepted, memwrite never asserted, BRESP=10. A second burst with WID mismatch on beat 1 -> only beat 1 suppressed, BRESP=10.
- ARESETn high during beat 2 of an INCR AWLEN=7 burst -> next cycle AWREADY=1, WREADY=0, BVALID=0; a fresh burst completes with BRESP=00.
- WSLV_AW_SKID_EN defined: second AW offered during DATA -> accepted; its first beat is accepted the cycle after the first B handshake.
